instr_mem_pipelined: RTL and testbench
======================================

Name: instr_mem_pipelined

Overview:
Parametrised, pipelined instruction memory for the RV32IM fetch stage. It replaces a purely combinational array lookup with a valid/ready request/response interface and a configurable read latency. It also adds alignment and range fault detection, a flush for branch redirects, and a synchronous program-load write port for bootloading and testbenches. It sits between the PC/fetch logic and the IF/ID pipeline register.

Parameters:
DATA_WIDTH, 32, instruction word width in bits
DEPTH, 1024, number of instruction words (power of two, >= 4)
ADDR_WIDTH, 32, byte-address width of REQ_ADDR and LOAD_ADDR
LATENCY, 2, cycles from request acceptance to RESP_VALID (legal 1..4)
NOP_WORD, 32'h00000013, word returned on faulted or empty responses (ADDI x0,x0,0)

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  synchronous, active-high reset
REQ_VALID  in  1  fetch request present
REQ_READY  out  1  request accepted when REQ_VALID && REQ_READY at the edge
REQ_ADDR  in  ADDR_WIDTH  byte address (PC)
FLUSH  in  1  discard all in-flight and held responses
RESP_VALID  out  1  response present
RESP_READY  in  1  consumer accepts response
RESP_INSTR  out  DATA_WIDTH  fetched instruction
RESP_ADDR  out  ADDR_WIDTH  PC of the response
RESP_FAULT  out  2  bit0 misaligned, bit1 out of range
LOAD_EN  in  1  program-load write strobe
LOAD_ADDR  in  ADDR_WIDTH  byte address of write
LOAD_DATA  in  DATA_WIDTH  word to write
LOAD_ERR  out  1  one-cycle pulse: rejected write
IN_FLIGHT  out  3  number of valid entries in pipeline incl. output stage

Behaviour:
- Addressing: byte addressed. Word index = ADDR[clog2(DEPTH)+1:2].
  - Misaligned: ADDR[1:0] != 0.
  - Out of range: ADDR >= DEPTH*4.
  - Both fault bits may be set together.
- Faulted request: still accepted and travels the pipeline. Its response carries RESP_INSTR = NOP_WORD and the fault bits. The array is not read.
- Pipeline: LATENCY stages, each holding {valid, instr, addr, fault}. The last stage drives the RESP_* outputs.
  - The array is sampled at the acceptance edge into stage 1.
  - In-flight data is unaffected by later writes.
- Latency: with RESP_READY held high, a request accepted at edge N gives RESP_VALID=1 in the cycle following edge N+LATENCY-1. LATENCY=1 means the response is visible right after the accepting edge.
- Throughput: with no stall, one request is accepted and one response delivered per cycle.
- Stall: when RESP_VALID && !RESP_READY, the entire pipeline holds.
  - RESP_INSTR, RESP_ADDR and RESP_FAULT stay stable.
  - REQ_READY = 0.
  - Bubbles do not compress.
- REQ_READY = !RESET && !FLUSH && !LOAD_EN && !(RESP_VALID && !RESP_READY). It is combinational.
- FLUSH: at the edge, all stage valid bits clear.
  - No request is accepted that cycle.
  - The next cycle has RESP_VALID=0 and IN_FLIGHT=0.
  - FLUSH overrides a stall.
- Load port: LOAD_EN at an edge writes LOAD_DATA to the addressed word if aligned and in range. Otherwise there is no write and LOAD_ERR=1 for the next cycle.
  - LOAD_EN blocks new requests (REQ_READY=0) but does not stall in-flight responses.
  - A read accepted on the edge after a write returns the new data.
- Simultaneous LOAD_EN and FLUSH: both take effect.
- IN_FLIGHT: count of valid stages, updated each edge. It must never exceed LATENCY.
- RESET, including mid-operation: all valid bits 0, RESP_VALID=0, RESP_INSTR=NOP_WORD, RESP_ADDR=0, RESP_FAULT=0, LOAD_ERR=0, IN_FLIGHT=0. Array contents are preserved.
- Power-up array contents: all words NOP_WORD via an initial block.

Test Plan:
- Basic pipelined read: load 0x00100113 @0x14 and 0x002081B3 @0x24, LATENCY=2. Issue back-to-back requests 0x14, 0x24 with RESP_READY=1 -> responses 0x00100113 then 0x002081B3 on consecutive cycles, 2 cycles after each accept, with RESP_ADDR matching and RESP_FAULT=0.
- Faults: request 0x16 -> NOP_WORD, FAULT=2'b01. Request 0x1000 (DEPTH=1024) -> NOP_WORD, FAULT=2'b10. Request 0x1002 -> FAULT=2'b11.
- Backpressure: stream 0x0, 0x4, 0x8 and drop RESP_READY for 3 cycles while 0x0 is presented -> outputs stable, REQ_READY=0, IN_FLIGHT=2. On release, responses 0x0, 0x4, 0x8 in order with none lost or duplicated.
- Flush: two requests in flight, assert FLUSH with REQ_VALID=1 @0x30 -> next cycle RESP_VALID=0, IN_FLIGHT=0, and no response for 0x30 ever appears.
- Load port: LOAD_EN @0x44 with data 0x40208133, then request 0x44 on the following edge -> returns 0x40208133. LOAD_EN @0x46 -> LOAD_ERR pulse and word 0x44 unchanged.
- Reset mid-stream: RESET with 2 requests in flight -> next cycle RESP_VALID=0, RESP_INSTR=0x00000013, IN_FLIGHT=0. A later read of 0x44 still returns 0x40208133.

Source files
------------

// File: rtl/instr_mem_pipelined.sv
// Pipelined instruction memory for the RV32IM fetch stage.
// It has a valid/ready request/response interface with a fixed read latency.
// Faulted requests (misaligned or out of range) still travel the pipeline and return NOP_WORD.
// The synchronous load port is used for bootloading.
module instr_mem_pipelined #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    LATENCY    = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h00000013
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic                  FLUSH,
  output logic                  RESP_VALID,
  input  logic                  RESP_READY,
  output logic [DATA_WIDTH-1:0] RESP_INSTR,
  output logic [ADDR_WIDTH-1:0] RESP_ADDR,
  output logic [1:0]            RESP_FAULT,
  input  logic                  LOAD_EN,
  input  logic [ADDR_WIDTH-1:0] LOAD_ADDR,
  input  logic [DATA_WIDTH-1:0] LOAD_DATA,
  output logic                  LOAD_ERR,
  output logic [2:0]            IN_FLIGHT
);

  localparam int unsigned            LAT   = unsigned'(LATENCY);
  localparam int                     IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]    LIMIT = (ADDR_WIDTH+1)'(DEPTH * 4);

  // Array powers up holding NOP_WORD; reset never touches it.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: NOP_WORD};

  // Pipeline stages; index LAT-1 is the output stage.
  logic                  r_valid [LAT];
  logic [DATA_WIDTH-1:0] r_instr [LAT];
  logic [ADDR_WIDTH-1:0] r_addr  [LAT];
  logic [1:0]            r_fault [LAT];
  logic [2:0]            r_in_flight;
  logic                  r_load_err;

  logic                  w_stall;
  logic                  w_accept;
  logic [1:0]            w_req_fault;
  logic [1:0]            w_load_fault;
  logic [IDX_W-1:0]      w_req_idx;
  logic [IDX_W-1:0]      w_load_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_vnext [LAT];
  logic [2:0]            w_count;

  // bit1: out of range, bit0: misaligned
  function automatic logic [1:0] f_fault(input logic [ADDR_WIDTH-1:0] a);
    return {({1'b0, a} >= LIMIT), (a[1:0] != 2'b00)};
  endfunction

  assign w_req_fault  = f_fault(REQ_ADDR);
  assign w_load_fault = f_fault(LOAD_ADDR);
  assign w_req_idx    = REQ_ADDR[IDX_W+1:2];
  assign w_load_idx   = LOAD_ADDR[IDX_W+1:2];
  assign w_rd_word    = r_mem[w_req_idx];

  assign w_stall   = r_valid[LAT-1] && !RESP_READY;
  assign REQ_READY = !RESET && !FLUSH && !LOAD_EN && !w_stall;
  assign w_accept  = REQ_VALID && REQ_READY;

  assign RESP_VALID = r_valid[LAT-1];
  assign RESP_INSTR = r_instr[LAT-1];
  assign RESP_ADDR  = r_addr[LAT-1];
  assign RESP_FAULT = r_fault[LAT-1];
  assign LOAD_ERR   = r_load_err;
  assign IN_FLIGHT  = r_in_flight;

  // Program-load write; rejected writes leave the array untouched.
  always_ff @(posedge CLK) begin
    if (LOAD_EN && (w_load_fault == 2'b00)) begin
      r_mem[w_load_idx] <= LOAD_DATA;
    end
  end

  // Next valid bits and their population count.
  // Flush wins over stall, so a held response is dropped as well.
  always_comb begin
    w_count = '0;
    for (int unsigned k = 0; k < LAT; k++) begin
      w_vnext[k] = r_valid[k];
    end
    if (FLUSH) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        w_vnext[k] = 1'b0;
      end
    end else if (!w_stall) begin
      w_vnext[0] = w_accept;
      for (int unsigned k = 1; k < LAT; k++) begin
        w_vnext[k] = r_valid[k-1];
      end
    end
    for (int unsigned k = 0; k < LAT; k++) begin
      if (w_vnext[k]) begin
        w_count = w_count + 3'd1;
      end
    end
  end

  // Pipeline advance, load-error pulse and occupancy counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        r_valid[k] <= 1'b0;
        r_instr[k] <= NOP_WORD;
        r_addr[k]  <= '0;
        r_fault[k] <= '0;
      end
      r_in_flight <= '0;
      r_load_err  <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < LAT; k++) begin
        r_valid[k] <= w_vnext[k];
      end
      if (!w_stall) begin
        // Bubbles enter as NOP/0/0 so an empty output stage shows NOP_WORD.
        r_instr[0] <= (w_accept && (w_req_fault == 2'b00)) ? w_rd_word : NOP_WORD;
        r_addr[0]  <= w_accept ? REQ_ADDR : '0;
        r_fault[0] <= w_accept ? w_req_fault : 2'b00;
        for (int unsigned k = 1; k < LAT; k++) begin
          r_instr[k] <= r_instr[k-1];
          r_addr[k]  <= r_addr[k-1];
          r_fault[k] <= r_fault[k-1];
        end
      end
      r_in_flight <= w_count;
      r_load_err  <= LOAD_EN && (w_load_fault != 2'b00);
    end
  end

endmodule

// File: tb/tb_instr_mem_pipelined.sv
// Self-checking bench for instr_mem_pipelined.
// It uses a scoreboard queue of expected responses and a table of fetch vectors.
module tb_instr_mem_pipelined;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int          LAT = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [31:0] REQ_ADDR = '0;
  logic        FLUSH = 1'b0;
  logic        RESP_VALID;
  logic        RESP_READY = 1'b1;
  logic [31:0] RESP_INSTR;
  logic [31:0] RESP_ADDR;
  logic [1:0]  RESP_FAULT;
  logic        LOAD_EN = 1'b0;
  logic [31:0] LOAD_ADDR = '0;
  logic [31:0] LOAD_DATA = '0;
  logic        LOAD_ERR;
  logic [2:0]  IN_FLIGHT;

  instr_mem_pipelined #(
    .DATA_WIDTH(32), .DEPTH(1024), .ADDR_WIDTH(32), .LATENCY(LAT), .NOP_WORD(NOP)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
    .FLUSH(FLUSH),
    .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY), .RESP_INSTR(RESP_INSTR),
    .RESP_ADDR(RESP_ADDR), .RESP_FAULT(RESP_FAULT),
    .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA),
    .LOAD_ERR(LOAD_ERR), .IN_FLIGHT(IN_FLIGHT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [1:0]  fault;
    bit          chk_lat;
    int          push_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [1:0]  fault;
  } vec_t;

  exp_t        sb[$];
  exp_t        exp_pend;
  exp_t        mon_e;
  logic [31:0] mdl [int unsigned];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] ins,
                              input logic [1:0] f, input bit lat);
    exp_t e;
    e.instr = ins; e.addr = a; e.fault = f; e.chk_lat = lat; e.push_cyc = 0;
    return e;
  endfunction

  // Reference behaviour of a fetch, computed from the bench's own memory image.
  function automatic exp_t model(input logic [31:0] a, input bit lat);
    logic [1:0]  f;
    logic [31:0] ins;
    f   = {(a >= 32'h1000), (a[1:0] != 2'b00)};
    ins = NOP;
    if (f == 2'b00 && mdl.exists(a >> 2)) ins = mdl[a >> 2];
    return mk(a, ins, f, lat);
  endfunction

  // Monitor: compare delivered responses, drop on flush/reset, record accepted requests.
  always @(negedge CLK) begin
    if (RESP_VALID === 1'b1 && RESP_READY) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got addr %0h instr %0h with nothing expected", RESP_ADDR, RESP_INSTR);
      end else begin
        mon_e = sb.pop_front();
        chk("resp", {RESP_INSTR, RESP_ADDR[29:0], RESP_FAULT}, {mon_e.instr, mon_e.addr[29:0], mon_e.fault});
        if (RESP_ADDR[31:30] != mon_e.addr[31:30]) chk("resp_addr_hi", 64'(RESP_ADDR), 64'(mon_e.addr));
        if (mon_e.chk_lat) chk("latency", 64'(cyc - mon_e.push_cyc), 64'(LAT));
      end
    end
    if (FLUSH || RESET) sb.delete();
    if (REQ_VALID && REQ_READY === 1'b1) begin
      mon_e = exp_pend;
      mon_e.push_cyc = cyc;
      sb.push_back(mon_e);
    end
  end

  // Present one request until accepted (bounded); returns at posedge+1.
  task automatic send(input logic [31:0] a, input exp_t e);
    bit got = 1'b0;
    REQ_VALID = 1'b1; REQ_ADDR = a; exp_pend = e;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge CLK); #1;
      got = (REQ_READY === 1'b1);
      @(posedge CLK); #1;
    end
    if (!got) chk("accept_timeout", 64'(0), 64'(1));
    REQ_VALID = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    LOAD_EN = 1'b1; LOAD_ADDR = a; LOAD_DATA = d;
    if (a[1:0] == 2'b00 && a < 32'h1000) mdl[a >> 2] = d;
    @(negedge CLK); #2;
    chk("load_blocks_req", 64'(REQ_READY), 64'(0));
    @(posedge CLK); #1;
    LOAD_EN = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && sb.size() != 0; n++) @(posedge CLK);
    repeat (LAT + 2) @(posedge CLK);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[6];
    logic [31:0] s_instr, s_addr;

    vt[0] = '{addr: 32'h16,       instr: NOP,          fault: 2'b01};
    vt[1] = '{addr: 32'h1000,     instr: NOP,          fault: 2'b10};
    vt[2] = '{addr: 32'h1002,     instr: NOP,          fault: 2'b11};
    vt[3] = '{addr: 32'h14,       instr: 32'h00100113, fault: 2'b00};
    vt[4] = '{addr: 32'hFFFFFFFC, instr: NOP,          fault: 2'b10};
    vt[5] = '{addr: 32'hFFC,      instr: NOP,          fault: 2'b00};

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_resp_valid", 64'(RESP_VALID), 64'(0));
    chk("rst_resp_instr", 64'(RESP_INSTR), 64'(NOP));
    chk("rst_resp_addr", 64'(RESP_ADDR), 64'(0));
    chk("rst_resp_fault", 64'(RESP_FAULT), 64'(0));
    chk("rst_in_flight", 64'(IN_FLIGHT), 64'(0));
    chk("rst_load_err", 64'(LOAD_ERR), 64'(0));
    chk("rst_req_ready", 64'(REQ_READY), 64'(0));
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Program image
    load(32'h14, 32'h00100113);
    load(32'h24, 32'h002081B3);
    load(32'h0,  32'hAAAA0001);
    load(32'h4,  32'hBBBB0002);
    load(32'h8,  32'hCCCC0003);
    chk("load_err_good", 64'(LOAD_ERR), 64'(0));

    // Basic back-to-back read with latency check
    send(32'h14, model(32'h14, 1'b1));
    send(32'h24, model(32'h24, 1'b1));
    drain();

    // Fault / boundary vectors, streamed back to back
    for (int i = 0; i < 6; i++) send(vt[i].addr, mk(vt[i].addr, vt[i].instr, vt[i].fault, 1'b1));
    drain();

    // Backpressure: stall while 0x0 is presented
    RESP_READY = 1'b0;
    send(32'h0, model(32'h0, 1'b0));
    send(32'h4, model(32'h4, 1'b0));
    fork
      send(32'h8, model(32'h8, 1'b0));
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge CLK); #2;
          if (c == 0) begin s_instr = RESP_INSTR; s_addr = RESP_ADDR; end
          chk("stall_req_ready", 64'(REQ_READY), 64'(0));
          chk("stall_in_flight", 64'(IN_FLIGHT), 64'(2));
          chk("stall_resp", {RESP_VALID, RESP_ADDR, RESP_FAULT}, {1'b1, 32'h0, 2'b00});
          chk("stall_instr", 64'(RESP_INSTR), 64'(32'hAAAA0001));
          chk("stall_stable", {s_instr, s_addr}, {RESP_INSTR, RESP_ADDR});
        end
        @(posedge CLK); #1;
        RESP_READY = 1'b1;
      end
    join
    drain();

    // Flush with two in flight, output stalled, and a new request pending
    send(32'h14, model(32'h14, 1'b0));
    send(32'h24, model(32'h24, 1'b0));
    FLUSH = 1'b1; RESP_READY = 1'b0; REQ_VALID = 1'b1; REQ_ADDR = 32'h30;
    exp_pend = model(32'h30, 1'b0);
    @(negedge CLK); #2;
    chk("flush_req_ready", 64'(REQ_READY), 64'(0));
    @(posedge CLK); #1;
    FLUSH = 1'b0; REQ_VALID = 1'b0; RESP_READY = 1'b1;
    @(negedge CLK);
    chk("flush_resp_valid", 64'(RESP_VALID), 64'(0));
    chk("flush_in_flight", 64'(IN_FLIGHT), 64'(0));
    drain();

    // Load port: write then read on the following edge, then rejected writes
    load(32'h44, 32'h40208133);
    send(32'h44, model(32'h44, 1'b0));
    drain();
    load(32'h46, 32'hDEADBEEF);
    @(negedge CLK);
    chk("load_err_misaligned", 64'(LOAD_ERR), 64'(1));
    @(negedge CLK);
    chk("load_err_pulse_end", 64'(LOAD_ERR), 64'(0));
    load(32'h2000, 32'h12345678);
    @(negedge CLK);
    chk("load_err_range", 64'(LOAD_ERR), 64'(1));
    send(32'h44, mk(32'h44, 32'h40208133, 2'b00, 1'b0));
    drain();

    // Reset mid-stream
    send(32'h14, model(32'h14, 1'b0));
    send(32'h24, model(32'h24, 1'b0));
    RESET = 1'b1; RESP_READY = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0; RESP_READY = 1'b1;
    @(negedge CLK);
    chk("mrst_resp_valid", 64'(RESP_VALID), 64'(0));
    chk("mrst_resp_instr", 64'(RESP_INSTR), 64'(NOP));
    chk("mrst_resp_addr", 64'(RESP_ADDR), 64'(0));
    chk("mrst_in_flight", 64'(IN_FLIGHT), 64'(0));
    @(posedge CLK); #1;
    send(32'h44, mk(32'h44, 32'h40208133, 2'b00, 1'b1));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
